clk_div_meas: RTL and testbench

CLK_DIV_MEAS -- requirements
Module: clk_div_meas

---
 rtl/clk_div_meas.sv | 84 ++++++++
 tb/tb_clk_div_meas.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_meas.sv
// clk_div_meas: measures period and high time of a slow asynchronous signal, with lock and timeout detection
module clk_div_meas #(
  parameter int W = 8,
  parameter int LOCK_N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         locked,
  output logic         timeout
);
  typedef enum logic {IDLE, MEAS} state_t;
  localparam logic [W-1:0] MAXP = '1;
  localparam logic [3:0] MLAST = 4'(LOCK_N - 1);
  state_t state_q;
  logic s1_q, s2_q, s3_q, rise;
  logic [W-1:0] per_q, hi_q, prev_q, period_q, high_q;
  logic prev_vld_q, valid_q, locked_q, timeout_q;
  logic [3:0] match_q, match_d;
  assign rise = s2_q & ~s3_q;
  assign period = period_q;
  assign high_time = high_q;
  assign valid = valid_q;
  assign locked = locked_q;
  assign timeout = timeout_q;
  // next match count: saturating run length of equal consecutive periods
  always_comb begin
    match_d = (prev_vld_q && per_q == prev_q) ? ((match_q == MLAST) ? MLAST : match_q + 4'd1) : 4'd0;
  end
  // synchronizer, measurement FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
      state_q <= IDLE;
      per_q <= '0;
      hi_q <= '0;
      prev_q <= '0;
      prev_vld_q <= 1'b0;
      match_q <= '0;
      period_q <= '0;
      high_q <= '0;
      valid_q <= 1'b0;
      locked_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      valid_q <= 1'b0;
      timeout_q <= 1'b0;
      if (state_q == IDLE) begin
        if (rise) begin
          per_q <= {{(W-1){1'b0}}, 1'b1};
          hi_q <= {{(W-1){1'b0}}, 1'b1};
          state_q <= MEAS;
        end
      end else if (rise) begin
        period_q <= per_q;
        high_q <= hi_q;
        valid_q <= 1'b1;
        prev_q <= per_q;
        prev_vld_q <= 1'b1;
        match_q <= match_d;
        locked_q <= (match_d == MLAST);
        per_q <= {{(W-1){1'b0}}, 1'b1};
        hi_q <= {{(W-1){1'b0}}, 1'b1};
      end else if (per_q == MAXP) begin
        timeout_q <= 1'b1;
        locked_q <= 1'b0;
        match_q <= '0;
        prev_vld_q <= 1'b0;
        state_q <= IDLE;
      end else begin
        per_q <= per_q + {{(W-1){1'b0}}, 1'b1};
        hi_q <= hi_q + {{(W-1){1'b0}}, s2_q};
      end
    end
  end
endmodule

// File: tb/tb_clk_div_meas.sv
// tb_clk_div_meas: edge-timestamp reference model with per-cycle compare plus directed literal checks
module tb_clk_div_meas;
  localparam int W = 8;
  localparam int LN = 4;
  localparam int MAXP = (1 << W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic valid, locked, timeout;
  int checks = 0;
  int failures = 0;
  int n = 0;
  int F = 0;
  bit samp [0:8191];
  bit s2v [0:8191];
  bit m_meas = 1'b0;
  int L = 0;
  int pq [$];
  logic [W-1:0] e_per = '0;
  logic [W-1:0] e_hi = '0;
  bit e_valid = 1'b0;
  bit e_to = 1'b0;
  bit e_lock = 1'b0;
  int vcnt = 0;
  int tocnt = 0;
  int to_edge = 0;
  logic [W-1:0] per_at [0:255];
  logic [W-1:0] hi_at [0:255];
  bit lock_at [0:255];
  int ve_at [0:255];
  int kr [0:15];
  int b0, c0, d0, t0, e0, f0, g0;

  clk_div_meas #(.W(W), .LOCK_N(LN)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .valid(valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic bit smp(input int i);
    return (i >= F && i >= 0) ? samp[i] : 1'b0;
  endfunction

  // reference model: rise = synchronized sample 2 edges old high and 3 edges old low
  always @(posedge clk) begin : mdl
    bit s2, s3, rs;
    int h;
    if (rst) begin
      m_meas = 1'b0;
      pq.delete();
      e_per = '0;
      e_hi = '0;
      e_valid = 1'b0;
      e_to = 1'b0;
      e_lock = 1'b0;
      F = n + 1;
    end else begin
      samp[n] = sig_in;
      s2 = smp(n - 2);
      s3 = smp(n - 3);
      s2v[n] = s2;
      rs = s2 && !s3;
      e_valid = 1'b0;
      e_to = 1'b0;
      if (!m_meas) begin
        if (rs) begin
          m_meas = 1'b1;
          L = n;
        end
      end else if (rs) begin
        h = 0;
        for (int m = L; m < n; m++) h += int'(s2v[m]);
        e_per = W'(n - L);
        e_hi = W'(h);
        e_valid = 1'b1;
        pq.push_back(n - L);
        e_lock = 1'b0;
        if (pq.size() >= LN) begin
          e_lock = 1'b1;
          for (int j = 1; j < LN; j++)
            if (pq[pq.size() - 1 - j] != pq[pq.size() - 1]) e_lock = 1'b0;
        end
        L = n;
      end else if (n - L == MAXP) begin
        e_to = 1'b1;
        e_lock = 1'b0;
        pq.delete();
        m_meas = 1'b0;
      end
    end
    n++;
  end

  // per-cycle comparison against the model and event recording
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", int'(valid), int'(e_valid));
      chk("timeout", int'(timeout), int'(e_to));
      chk("locked", int'(locked), int'(e_lock));
      chk("period", int'(period), int'(e_per));
      chk("high_time", int'(high_time), int'(e_hi));
      chk("valid_timeout_excl", int'(valid && timeout), 0);
      if (valid) begin
        chk("high_le_period", int'(high_time <= period), 1);
        if (vcnt < 255) begin
          vcnt++;
          per_at[vcnt] = period;
          hi_at[vcnt] = high_time;
          lock_at[vcnt] = locked;
          ve_at[vcnt] = n - 1;
        end
      end
      if (timeout) begin
        tocnt++;
        to_edge = n - 1;
      end
    end
  end

  task automatic run(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      sig_in = 1'b1;
      if (r < 16) kr[r] = n;
      repeat (hi) @(negedge clk);
      sig_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_period"}, int'(period), 0);
    chk({nm, "_high"}, int'(high_time), 0);
    chk({nm, "_valid"}, int'(valid), 0);
    chk({nm, "_locked"}, int'(locked), 0);
    chk({nm, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    b0 = vcnt;
    run(2, 3, 6);
    chk("B_nvalid", vcnt - b0, 5);
    chk("B_period", int'(per_at[b0 + 1]), 5);
    chk("B_high", int'(hi_at[b0 + 1]), 2);
    chk("B_latency", ve_at[b0 + 1], kr[1] + 2);
    chk("B_lock3", int'(lock_at[b0 + 3]), 0);
    chk("B_lock4", int'(lock_at[b0 + 4]), 1);
    c0 = vcnt;
    run(2, 4, 1);
    run(2, 3, 6);
    chk("C_nvalid", vcnt - c0, 7);
    chk("C_lock1", int'(lock_at[c0 + 1]), 1);
    chk("C_per6", int'(per_at[c0 + 2]), 6);
    chk("C_drop", int'(lock_at[c0 + 2]), 0);
    chk("C_lock5", int'(lock_at[c0 + 5]), 0);
    chk("C_relock", int'(lock_at[c0 + 6]), 1);
    d0 = vcnt;
    t0 = tocnt;
    repeat (300) @(negedge clk);
    chk("D_ntimeout", tocnt - t0, 1);
    chk("D_nvalid", vcnt - d0, 0);
    chk("D_delay", to_edge - ve_at[vcnt], 255);
    chk("D_locked", int'(locked), 0);
    e0 = vcnt;
    t0 = tocnt;
    run(2, 253, 1);
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("E_nvalid", vcnt - e0, 1);
    chk("E_period", int'(per_at[e0 + 1]), 255);
    chk("E_ntimeout", tocnt - t0, 0);
    sig_in = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_zero("F_async");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = vcnt;
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    run(2, 3, 1);
    chk("F_nvalid", vcnt - f0, 1);
    chk("F_period", int'(per_at[f0 + 1]), 5);
    chk("F_high", int'(hi_at[f0 + 1]), 2);
    g0 = vcnt;
    @(negedge clk);
    #2;
    repeat (40) begin
      sig_in = ~sig_in;
      #15;
    end
    @(negedge clk);
    repeat (4) @(negedge clk);
    chk("G_per", int'(per_at[g0 + 2]), 3);
    chk("G_high", int'(hi_at[g0 + 2] == 1 || hi_at[g0 + 2] == 2), 1);
    chk("G_lock4", int'(lock_at[g0 + 4]), 0);
    chk("G_lock5", int'(lock_at[g0 + 5]), 1);
    chk("G_last", int'(per_at[vcnt]), 3);
    t0 = tocnt;
    repeat (300) @(negedge clk);
    chk("G_timeout", tocnt - t0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
